// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: instruction memory port, hazard/redirect controls and IF/ID outputs.
// master = fetch unit side, slave = pipeline/memory side.
`timescale 1ns/1ps

interface instruction_fetch_unit_if;
    logic [31:0] InstrAddress;
    logic [31:0] InstrIn;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PCPlus4;
    logic        IF_Valid;
    logic        FetchFault;
    logic [31:0] FetchCount;

    modport master (
        output InstrAddress,
        output IF_Instruction,
        output IF_PCPlus4,
        output IF_Valid,
        output FetchFault,
        output FetchCount,
        input  InstrIn,
        input  Stall,
        input  Redirect,
        input  RedirectTarget
    );

    modport slave (
        input  InstrAddress,
        input  IF_Instruction,
        input  IF_PCPlus4,
        input  IF_Valid,
        input  FetchFault,
        input  FetchCount,
        output InstrIn,
        output Stall,
        output Redirect,
        output RedirectTarget
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: owns the PC, reads a combinational instruction memory and fills IF/ID.
// Handles stall, redirect-with-flush, and a sticky fault on misaligned/out-of-range PCs.
`timescale 1ns/1ps

module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic                     Clk,
    input  logic                     Reset,
    instruction_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_e;

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc_plus4;
    logic        pc_bad;

    assign pc_plus4 = pc_q + 32'd4;
    assign pc_bad   = (pc_q[1:0] != 2'b00) || (pc_q[31:2] >= WORD_LIMIT);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path through the case can infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        fault_d = fault_q;
        count_d = count_q;

        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end

            RUN: begin
                if (bus.Redirect) begin
                    // A redirect wins even over a bad current PC: that PC is on the wrong path.
                    pc_d    = bus.RedirectTarget;
                    instr_d = 32'd0;
                    pcp4_d  = 32'd0;
                    valid_d = 1'b0;
                end else if (pc_bad) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                    instr_d = 32'd0;
                    valid_d = 1'b0;
                end else if (!bus.Stall) begin
                    pc_d    = pc_plus4;
                    instr_d = bus.InstrIn;
                    pcp4_d  = pc_plus4;
                    valid_d = 1'b1;
                    count_d = count_q + 32'd1;
                end
            end

            FAULT: begin
                valid_d = 1'b0;
            end

            default: begin
                state_d = FAULT;
                fault_d = 1'b1;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            pcp4_q  <= 32'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign bus.InstrAddress   = pc_q;
    assign bus.IF_Instruction = instr_q;
    assign bus.IF_PCPlus4     = pcp4_q;
    assign bus.IF_Valid       = valid_q;
    assign bus.FetchFault     = fault_q;
    assign bus.FetchCount     = count_q;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front end of the single-cycle-memory MIPS pipeline.
- Owns the PC and drives the byte address into the instruction memory, which responds combinationally with Memory[Address[31:2]].
- Captures the returned word into the IF/ID register with a valid bit.
- Supports stall, branch/jump redirect with flush, and an out-of-range/misaligned fetch fault that halts fetch until reset.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of first fetch after reset.
- MEM_WORDS, 1024, number of valid instruction words; word index PC[31:2] must be < MEM_WORDS.

Ports:
- Clk, input, 1, system clock; all state updates on rising edge.
- Reset, input, 1, asynchronous, active-low reset.
- InstrAddress, output, 32, byte address to instruction memory; equals PC register (combinational from PC).
- InstrIn, input, 32, instruction word returned by instruction memory in the same cycle.
- Stall, input, 1, hazard unit request to hold PC and IF/ID.
- Redirect, input, 1, taken branch/jump from later stage.
- RedirectTarget, input, 32, byte address to fetch next when Redirect=1.
- IF_Instruction, output, 32, registered fetched instruction (0 = NOP when invalid).
- IF_PCPlus4, output, 32, registered PC+4 of fetched instruction.
- IF_Valid, output, 1, IF/ID contents are a real instruction.
- FetchFault, output, 1, sticky fault flag.
- FetchCount, output, 32, number of instructions delivered with IF_Valid=1 since reset.

Behaviour:
- Reset (Reset=0, any time, asynchronous):
  - PC=RESET_PC, IF_Instruction=0, IF_PCPlus4=0, IF_Valid=0, FetchFault=0, FetchCount=0, state=BOOT.
  - Mid-run reset discards all in-flight state immediately.
- States: BOOT, RUN, FAULT.
- BOOT:
  - Lasts exactly one clock after Reset deasserts.
  - IF_Valid stays 0 and PC holds; inputs are ignored.
  - Next state is RUN.
- RUN, evaluated each rising edge, priority Redirect > fault check > Stall > advance:
  - Redirect=1:
    - PC<=RedirectTarget.
    - IF_Valid<=0, IF_Instruction<=0, IF_PCPlus4<=0 (flush).
    - Overrides Stall and any pending fault on the current PC.
    - FetchCount unchanged.
  - Fault check (Redirect=0): if PC[1:0]!=0 or PC[31:2]>=MEM_WORDS:
    - state<=FAULT, FetchFault<=1.
    - IF_Valid<=0, IF_Instruction<=0.
    - PC holds the offending address.
    - Checked even when Stall=1.
  - Stall=1 (no redirect, no fault): PC, IF_Instruction, IF_PCPlus4, IF_Valid, FetchCount all hold.
  - Advance:
    - IF_Instruction<=InstrIn, IF_PCPlus4<=PC+4, IF_Valid<=1.
    - PC<=PC+4, modulo 2^32.
    - FetchCount<=FetchCount+1, wraps at 2^32.
- FAULT:
  - Absorbing; only Reset exits.
  - FetchFault=1, IF_Valid=0, PC frozen; Stall and Redirect are ignored.
- Latency: the instruction at PC appears on IF_Instruction one cycle after PC is presented.
- A misaligned RedirectTarget is accepted into PC; the fault is raised on the following edge.
- InstrAddress always equals PC, including in BOOT, FAULT and stall.

Test Plan:
- Reset release, memory[i]=i*3, no stall:
  - BOOT cycle shows IF_Valid=0.
  - Next edges give IF_Instruction=0,3,6,9 with IF_PCPlus4=4,8,12,16.
  - FetchCount=4.
- Stall=1 for 3 cycles while PC=8: InstrAddress stays 8; IF_Instruction=3, IF_Valid=1 and FetchCount held; on release, IF_Instruction=6.
- Redirect=1 with RedirectTarget=40 together with Stall=1:
  - Next edge: IF_Valid=0, IF_Instruction=0, PC=40.
  - Following edge: IF_Instruction=30, IF_PCPlus4=44.
- RedirectTarget=42: PC=42, then FetchFault=1 and IF_Valid=0 next edge; a subsequent Redirect to 0 is ignored and PC stays 42.
- Sequential run past PC=4092 with MEM_WORDS=1024: the word at 4092 is delivered, then PC=4096 faults with FetchFault=1 and FetchCount=1024.
- Assert Reset low mid-cycle during RUN at PC=100:
  - Outputs go to reset values immediately, without waiting for a clock.
  - After release: one BOOT bubble, then the fetch restarts at RESET_PC.
